fp_add_normalize_round: RTL and testbench
=========================================

# fp_add_normalize_round

Post-add normalize-and-round stage of the single-precision floating-point adder. It accepts the raw signed-magnitude sum produced by the align/add stage and normalizes it: right-shift on carry-out, iterative left-shift after cancellation. It then applies IEEE-754 round-to-nearest-even and emits a packed 32-bit result with status flags. Valid/ready handshakes are used on both sides.

## Interface
Parameters: none.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  upstream sum available
- in_ready  out  1  block can accept; high only in IDLE
- in_sign  in  1  sign of sum
- in_exp  in  8  biased exponent of larger operand; 0 treated as 1; 255 means Inf/NaN passthrough
- in_mant  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
- out_valid  out  1  result held valid
- out_ready  in  1  downstream accepts
- out_result  out  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- out_overflow  out  1  result rounded to infinity
- out_inexact  out  1  any nonzero bit discarded (G|R|S after final shift)

## Operation
- States: IDLE, CHECK, SHIFT, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, register sign, exp, and mant, then go to CHECK.
- CHECK:
  - exp==255: out_result={sign,8'hFF,mant[25:3]}, flags 0, go to DONE.
  - mant==0: out_result={sign,31'b0}, go to DONE.
  - mant[27]=1: mant = mant>>1 with new bit0 = old bit1|old bit0 (sticky preserved); exp+=1; go to ROUND.
  - mant[26]=1: go to ROUND.
  - Otherwise: go to SHIFT.
- SHIFT, one bit per cycle:
  - If mant[26]=1, go to ROUND.
  - Else if exp==1, go to ROUND as denormal (exponent field 0).
  - Else mant<<=1 and exp-=1.
- ROUND:
  - L=mant[3], G=mant[2], R=mant[1], S=mant[0].
  - inc = G&(L|R|S); sum25 = {1'b0,mant[26:3]} + inc.
  - If sum25[24]=1: exp+=1 and fraction=0.
  - Denormal case: exponent field=0, unless rounding sets bit 23, in which case the field is 1.
  - Exponent ≥255 after rounding: out_result={sign,8'hFF,23'b0}, out_overflow=1.
  - out_inexact = G|R|S.
  - Go to DONE.
- DONE: out_valid=1; out_result and flags held stable until out_ready=1, then go to IDLE.
- Exponent arithmetic is done 9 bits wide internally to detect overflow.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=32'h0, out_overflow=0, out_inexact=0.
- Latency is measured from the accept edge to the first cycle with out_valid high:
  - 3 cycles for normalized, carry, zero, or Inf/NaN input.
  - 3+k cycles when k left shifts are needed.
  - Worst case k=26 gives 29 cycles.
- Throughput is one operation in flight. in_ready stays low from the accept edge until DONE completes.
- out_valid and out_ready both high at an edge completes the transfer. in_ready rises the following cycle, so there is no same-cycle accept.
- reset high at any edge, including mid-SHIFT or in DONE with out_ready low, aborts the operation. The next cycle shows the reset values and the in-flight result is discarded.
- in_* inputs are ignored while in_ready=0.

## Configuration
- FP_NORM_LZC_EN:
  - Defined: SHIFT completes in a single cycle. A leading-zero count on mant[26:0] gives shift = min(lzc, exp-1); mant<<=shift, exp-=shift, then go to ROUND. Latency for any shift case is fixed at 4.
  - Undefined: bit-serial SHIFT as above; no LZC or barrel shifter is synthesized.
- Results and flags are identical in both builds.

## Test plan
- Normalized input: sign=0, exp=127, mant=28'h4000000 → out_result=32'h3F800000, inexact=0, out_valid 3 cycles after accept.
- Carry input: exp=127, mant=28'h8000000 → 32'h40000000, latency 3.
- Cancellation: exp=127, mant=28'h0000008 → 32'h34000000 after 23 shifts.
  - Latency 26 without FP_NORM_LZC_EN; latency 4 with it.
- Rounding ties:
  - mant=28'h4000004 (tie, L=0) → 32'h3F800000, inexact=1.
  - mant=28'h400000C (tie, L=1) → 32'h3F800002, inexact=1.
- Overflow and zero:
  - exp=254, mant=28'h8000000 → 32'h7F800000, overflow=1.
  - sign=1, mant=0 → 32'h80000000.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → out_result and flags stable, in_ready=0.
  - Assert reset during SHIFT → next cycle out_valid=0, in_ready=1, out_result=0.

Source files
------------

// File: rtl/fp_add_normalize_round_if.sv
// Handshake bundle between the FP adder align/add stage, the normalize/round stage and the result consumer.
// master = producer/consumer side, slave = fp_add_normalize_round.
interface fp_add_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_inexact
  );
endinterface

// File: rtl/fp_add_normalize_round.sv
// Post-add normalize and round-to-nearest-even stage of the single-precision adder.
// Define FP_NORM_LZC_EN for a single-cycle LZC/barrel-shift normalize; otherwise the left shift is bit-serial.
module fp_add_normalize_round (
  input  logic                     clk,
  input  logic                     reset,
  fp_add_normalize_round_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SHIFT = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r;
  logic        sign_r;
  logic [8:0]  exp_r;
  logic [27:0] mant_r;
  logic        special_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] out_result_r;
  logic        out_overflow_r;
  logic        out_inexact_r;

  logic        inc_s;
  logic [24:0] sum25_s;
  logic [8:0]  rexp_s;
  logic [7:0]  rfield_s;
  logic        rovf_s;

  logic [27:0] shl_mant_s;
  logic [8:0]  shl_exp_s;
  logic        shift_done_s;

  // Round-to-nearest-even on the normalized mantissa; a clear hidden bit here means denormal
  always_comb begin
    inc_s   = mant_r[2] & (mant_r[3] | mant_r[1] | mant_r[0]);
    sum25_s = {1'b0, mant_r[26:3]} + {24'd0, inc_s};
    if (sum25_s[24]) begin
      rexp_s = exp_r + 9'd1;
    end else begin
      rexp_s = exp_r;
    end
    if (!mant_r[26]) begin
      rfield_s = sum25_s[23] ? 8'd1 : 8'd0;
    end else begin
      rfield_s = rexp_s[7:0];
    end
    rovf_s = (rexp_s >= 9'd255);
  end

`ifdef FP_NORM_LZC_EN
  logic [4:0] lzc_s;
  logic [8:0] limit_s;
  logic [8:0] shamt_s;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) begin
        n = 5'(26 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Whole normalize in one step, clamped so the exponent never drops below 1
  always_comb begin
    lzc_s   = lzc27(mant_r[26:0]);
    limit_s = exp_r - 9'd1;
    if ({4'd0, lzc_s} > limit_s) begin
      shamt_s = limit_s;
    end else begin
      shamt_s = {4'd0, lzc_s};
    end
    shl_mant_s   = mant_r << shamt_s;
    shl_exp_s    = exp_r - shamt_s;
    shift_done_s = 1'b1;
  end
`else
  // One-bit shift with look-ahead exit, so k shifts cost exactly k cycles
  always_comb begin
    shl_mant_s   = {mant_r[26:0], 1'b0};
    shl_exp_s    = exp_r - 9'd1;
    shift_done_s = shl_mant_s[26] | (shl_exp_s == 9'd1);
  end
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      sign_r         <= 1'b0;
      exp_r          <= 9'd0;
      mant_r         <= 28'd0;
      special_r      <= 1'b0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      out_result_r   <= 32'h0;
      out_overflow_r <= 1'b0;
      out_inexact_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r     <= bus.in_sign;
            exp_r      <= (bus.in_exp == 8'd0) ? 9'd1 : {1'b0, bus.in_exp};
            mant_r     <= bus.in_mant;
            special_r  <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= CHECK;
          end else begin
            state_r <= IDLE;
          end
        end
        CHECK: begin
          if ((exp_r == 9'd255) || (mant_r == 28'd0)) begin
            special_r <= 1'b1;
            state_r   <= ROUND;
          end else if (mant_r[27]) begin
            // Keep the dropped bit alive in sticky
            mant_r  <= {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
            exp_r   <= exp_r + 9'd1;
            state_r <= ROUND;
          end else if (mant_r[26] || (exp_r == 9'd1)) begin
            state_r <= ROUND;
          end else begin
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          mant_r <= shl_mant_s;
          exp_r  <= shl_exp_s;
          if (shift_done_s) begin
            state_r <= ROUND;
          end else begin
            state_r <= SHIFT;
          end
        end
        ROUND: begin
          if (special_r) begin
            if (exp_r == 9'd255) begin
              out_result_r <= {sign_r, 8'hFF, mant_r[25:3]};
            end else begin
              out_result_r <= {sign_r, 31'd0};
            end
            out_overflow_r <= 1'b0;
            out_inexact_r  <= 1'b0;
          end else if (rovf_s) begin
            out_result_r   <= {sign_r, 8'hFF, 23'd0};
            out_overflow_r <= 1'b1;
            out_inexact_r  <= |mant_r[2:0];
          end else begin
            out_result_r   <= {sign_r, rfield_s, sum25_s[22:0]};
            out_overflow_r <= 1'b0;
            out_inexact_r  <= |mant_r[2:0];
          end
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_result   = out_result_r;
  assign bus.out_overflow = out_overflow_r;
  assign bus.out_inexact  = out_inexact_r;

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Directed vector bench for fp_add_normalize_round: result, flags, latency, backpressure and reset abort.
module tb_fp_add_normalize_round;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_add_normalize_round_if bus ();

  fp_add_normalize_round dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [31:0] res;
    logic        ovf;
    logic        inx;
    int          lat_ser;
    int          lat_lzc;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic start_op(input logic s, input logic [7:0] e, input logic [27:0] m);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b1;
    bus.in_exp   = 8'hAA;
    bus.in_mant  = 28'hFFFFFFF;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_xfer", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_after_xfer", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_out_result"}, bus.out_result, 32'h0);
    check({tag, "_overflow"}, {31'd0, bus.out_overflow}, 32'd0);
    check({tag, "_inexact"}, {31'd0, bus.out_inexact}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_lat;

    vecs[0]  = '{1'b0, 8'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 3, 3};
    vecs[1]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3, 3};
    vecs[2]  = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 26, 4};
    vecs[3]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 3, 3};
    vecs[4]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b1, 3, 3};
    vecs[5]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 3, 3};
    vecs[6]  = '{1'b1, 8'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 3, 3};
    vecs[7]  = '{1'b0, 8'd255, 28'h0000010, 32'h7F800002, 1'b0, 1'b0, 3, 3};
    vecs[8]  = '{1'b0, 8'd1,   28'h2000000, 32'h00400000, 1'b0, 1'b0, 3, 3};
    vecs[9]  = '{1'b0, 8'd0,   28'h4000000, 32'h00800000, 1'b0, 1'b0, 3, 3};
    vecs[10] = '{1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 1'b0, 1'b1, 3, 3};
    vecs[11] = '{1'b0, 8'd3,   28'h0800000, 32'h00400000, 1'b0, 1'b0, 5, 4};
    vecs[12] = '{1'b0, 8'd127, 28'h0000001, 32'h32800000, 1'b0, 1'b0, 29, 4};
    vecs[13] = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b1, 3, 3};
    vecs[14] = '{1'b0, 8'd127, 28'h8000003, 32'h40000000, 1'b0, 1'b1, 3, 3};
    vecs[15] = '{1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b1, 3, 3};
    vecs[16] = '{1'b1, 8'd130, 28'h6000000, 32'hC1400000, 1'b0, 1'b0, 3, 3};
    vecs[17] = '{1'b0, 8'd127, 28'h4000006, 32'h3F800001, 1'b0, 1'b1, 3, 3};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'd0;
    bus.in_mant   = 28'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values("reset");

    for (int i = 0; i < 18; i++) begin
`ifdef FP_NORM_LZC_EN
      exp_lat = vecs[i].lat_lzc;
`else
      exp_lat = vecs[i].lat_ser;
`endif
      start_op(vecs[i].sign, vecs[i].exp, vecs[i].mant);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, exp_lat);
      check($sformatf("v%0d_result", i), bus.out_result, vecs[i].res);
      check($sformatf("v%0d_overflow", i), {31'd0, bus.out_overflow}, {31'd0, vecs[i].ovf});
      check($sformatf("v%0d_inexact", i), {31'd0, bus.out_inexact}, {31'd0, vecs[i].inx});
      finish_op();
    end

    // Backpressure: result held while out_ready low; new input offered meanwhile is ignored
    start_op(1'b0, 8'd127, 28'h400000C);
    wait_valid(lat);
    bus.in_valid = 1'b1;
    bus.in_exp   = 8'd10;
    bus.in_mant  = 28'h8000000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_result", bus.out_result, 32'h3F800002);
      check("bp_inexact", {31'd0, bus.out_inexact}, 32'd1);
      check("bp_overflow", {31'd0, bus.out_overflow}, 32'd0);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    finish_op();

    // Reset in the middle of a long serial shift discards the operation
    start_op(1'b0, 8'd127, 28'h0000001);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_values("rst_shift");
    repeat (30) @(posedge clk);
    #1;
    check("rst_shift_discarded", {31'd0, bus.out_valid}, 32'd0);

    // Reset while a result is stalled in DONE
    start_op(1'b0, 8'd254, 28'h8000000);
    wait_valid(lat);
    check("rst_done_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_values("rst_done");

    // Recovery after reset
    start_op(1'b0, 8'd127, 28'h4000000);
    wait_valid(lat);
    check("recover_latency", lat, 3);
    check("recover_result", bus.out_result, 32'h3F800000);
    finish_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
